// File: rtl/ps2_keylog_if.sv
// ps2_keylog_if: pin, control and status bundle of the PS/2 key logger
//   PS2_CLK, PS2_DAT : raw asynchronous PS/2 pins (to logger)
//   iClear           : synchronous clear of history and error counter (to logger)
//   oData/oState     : last event scan code and {ext, brk, err} (from logger)
//   oTrig            : one-cycle pulse per completed key event (from logger)
//   oHist            : 12*DEPTH-bit event history, newest at [11:0] (from logger)
//   oErrCnt          : saturating bad-frame count (from logger)
interface ps2_keylog_if #(parameter int DEPTH = 4);
  logic                PS2_CLK;
  logic                PS2_DAT;
  logic                iClear;
  logic [7:0]          oData;
  logic [2:0]          oState;
  logic                oTrig;
  logic [12*DEPTH-1:0] oHist;
  logic [7:0]          oErrCnt;
  modport master (output PS2_CLK, PS2_DAT, iClear, input oData, oState, oTrig, oHist, oErrCnt);
  modport slave  (input PS2_CLK, PS2_DAT, iClear, output oData, oState, oTrig, oHist, oErrCnt);
endinterface

// File: rtl/ps2_keylog.sv
// ps2_keylog: PS/2 receiver with E0/F0 prefix decoding, error counting and event history
//   CLOCK : system clock, the only clock
//   RST_n : asynchronous active-low reset
//   bus   : ps2_keylog_if slave (pins, iClear, oData, oState, oTrig, oHist, oErrCnt)
module ps2_keylog #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int DEPTH       = 4
) (
  input logic         CLOCK,
  input logic         RST_n,
  ps2_keylog_if.slave bus
);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t              r_state, w_next;
  logic [1:0]          r_clk_s, r_dat_s;
  logic                r_filt;
  logic [FW-1:0]       r_cnt;
  logic [TW-1:0]       r_tmo;
  logic [2:0]          r_bit;
  logic [7:0]          r_shift, r_data, r_errcnt;
  logic                r_par, r_ext, r_brk, r_oext, r_obrk, r_err, r_trig;
  logic [12*DEPTH-1:0] r_hist, w_push;
  logic                w_clk, w_dat, w_fall, w_tmo, w_stop, w_good, w_bad, w_evt;
  logic [11:0]         w_entry;
  assign w_clk = r_clk_s[1];
  assign w_dat = r_dat_s[1];
  // a bit edge is the cycle in which the filtered clock commits to 0
  assign w_fall = r_filt & ~w_clk & (r_cnt == FW'(FILT_LEN - 1));
  assign w_tmo = (r_state != IDLE) & ~w_fall & (r_tmo == TW'(TIMEOUT_CYC - 1));
  assign w_entry = {2'b00, r_ext, r_brk, r_shift};
  if (DEPTH > 1) begin : g_shift
    assign w_push = {r_hist[12*DEPTH-13:0], w_entry};
  end else begin : g_single
    assign w_push = w_entry;
  end
  // synchronisers idle high so a reset never fakes a falling edge
  always_ff @(posedge CLOCK or negedge RST_n)
    if (!RST_n) begin
      r_clk_s <= 2'b11;
      r_dat_s <= 2'b11;
      r_filt  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_clk_s <= {r_clk_s[0], bus.PS2_CLK};
      r_dat_s <= {r_dat_s[0], bus.PS2_DAT};
      if (w_clk == r_filt) r_cnt <= '0;
      else if (r_cnt == FW'(FILT_LEN - 1)) begin
        r_filt <= w_clk;
        r_cnt  <= '0;
      end else r_cnt <= r_cnt + FW'(1);
    end
  always_ff @(posedge CLOCK or negedge RST_n)
    if (!RST_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (w_tmo) w_next = IDLE;
    else if (w_fall)
      case (r_state)
        IDLE:    w_next = w_dat ? IDLE : DATA;
        DATA:    w_next = (r_bit == 3'd7) ? PARITY : DATA;
        PARITY:  w_next = STOP;
        default: w_next = IDLE;
      endcase
  end
  always_comb begin
    w_stop = (r_state == STOP) & w_fall;
    w_good = w_stop & w_dat & (^{r_par, r_shift});
    w_bad  = (w_stop & ~w_good) | w_tmo;
    w_evt  = w_good & (r_shift != 8'hE0) & (r_shift != 8'hF0);
  end
  always_ff @(posedge CLOCK or negedge RST_n)
    if (!RST_n) begin
      r_tmo   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else begin
      r_tmo <= (r_state == IDLE || w_fall) ? '0 : r_tmo + TW'(1);
      if (w_fall) begin
        if (r_state == IDLE) r_bit <= '0;
        if (r_state == DATA) begin
          r_shift <= {w_dat, r_shift[7:1]};
          r_bit   <= r_bit + 3'd1;
        end
        if (r_state == PARITY) r_par <= w_dat;
      end
    end
  always_ff @(posedge CLOCK or negedge RST_n)
    if (!RST_n) begin
      r_ext    <= 1'b0;
      r_brk    <= 1'b0;
      r_data   <= '0;
      r_oext   <= 1'b0;
      r_obrk   <= 1'b0;
      r_err    <= 1'b0;
      r_trig   <= 1'b0;
      r_hist   <= '0;
      r_errcnt <= '0;
    end else begin
      r_trig <= w_evt;
      if (w_bad) begin
        r_err <= 1'b1;
        r_ext <= 1'b0;
        r_brk <= 1'b0;
        if (r_errcnt != 8'hFF) r_errcnt <= r_errcnt + 8'd1;
      end
      if (w_good) begin
        r_err <= 1'b0;
        r_ext <= r_ext | (r_shift == 8'hE0);
        r_brk <= r_brk | (r_shift == 8'hF0);
      end
      if (w_evt) begin
        r_data <= r_shift;
        r_oext <= r_ext;
        r_obrk <= r_brk;
        r_hist <= w_push;
        r_ext  <= 1'b0;
        r_brk  <= 1'b0;
      end
      // clear takes priority over a same-cycle push or error increment
      if (bus.iClear) begin
        r_hist   <= '0;
        r_errcnt <= '0;
      end
    end
  assign bus.oData   = r_data;
  assign bus.oState  = {r_oext, r_obrk, r_err};
  assign bus.oTrig   = r_trig;
  assign bus.oHist   = r_hist;
  assign bus.oErrCnt = r_errcnt;
endmodule

// File: tb/tb_ps2_keylog.sv
// tb_ps2_keylog: directed and randomized frames checked against a queue-based event model
module tb_ps2_keylog;
  localparam int FILT = 8;
  localparam int TMO  = 60;
  localparam int DEP  = 4;
  localparam int H    = 12;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0, checks = 0, trig_cnt = 0;
  ps2_keylog_if #(.DEPTH(DEP)) bus ();
  ps2_keylog #(.FILT_LEN(FILT), .TIMEOUT_CYC(TMO), .DEPTH(DEP)) dut (.CLOCK(clk), .RST_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.oTrig === 1'b1) trig_cnt <= trig_cnt + 1;
  logic [7:0]  m_data;
  logic        m_ext, m_brk, m_err, m_pe, m_pb, m_clr;
  int          m_cnt, m_trig;
  logic [11:0] q[$];
  function automatic void model_reset();
    m_data = 0; m_ext = 0; m_brk = 0; m_err = 0; m_pe = 0; m_pb = 0; m_cnt = 0;
    q.delete();
  endfunction
  function automatic void model(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_err = 1; m_pe = 0; m_pb = 0;
      if (m_cnt < 255) m_cnt++;
    end else begin
      m_err = 0;
      if (b == 8'hE0) m_pe = 1;
      else if (b == 8'hF0) m_pb = 1;
      else begin
        m_data = b; m_ext = m_pe; m_brk = m_pb;
        q.push_front({2'b00, m_pe, m_pb, b});
        if (q.size() > DEP) void'(q.pop_back());
        m_trig++;
        m_pe = 0; m_pb = 0;
      end
    end
    if (m_clr) begin q.delete(); m_cnt = 0; end
  endfunction
  function automatic logic [12*DEP-1:0] exp_hist();
    logic [12*DEP-1:0] h = '0;
    foreach (q[i]) h[12*i +: 12] = q[i];
    return h;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    @(negedge clk);
    chk({tag, " data"}, 64'(bus.oData), 64'(m_data));
    chk({tag, " state"}, 64'(bus.oState), 64'({m_ext, m_brk, m_err}));
    chk({tag, " hist"}, 64'(bus.oHist), 64'(exp_hist()));
    chk({tag, " errcnt"}, 64'(bus.oErrCnt), 64'(m_cnt));
    chk({tag, " trigs"}, 64'(trig_cnt), 64'(m_trig));
  endtask
  task automatic send_bit(input logic b);
    bus.PS2_DAT = b;
    repeat (H) @(posedge clk);
    bus.PS2_CLK = 1'b0;
    repeat (H) @(posedge clk);
    bus.PS2_CLK = 1'b1;
  endtask
  // kind: 0 good, 1 bad parity, 2 bad stop, 3 truncated after nbits then timeout
  task automatic frame(input logic [7:0] b, input int kind, input int nbits, input string tag);
    logic [10:0] f;
    f = {kind != 2, (~^b) ^ (kind == 1), b, 1'b0};
    for (int i = 0; i < (kind == 3 ? nbits : 11); i++) send_bit(f[i]);
    bus.PS2_DAT = 1'b1;
    repeat (kind == 3 ? TMO + 20 : 4) @(posedge clk);
    model(b, kind == 0);
    if (tag != "") check_all(tag);
  endtask
  initial begin
    bus.PS2_CLK = 1'b1; bus.PS2_DAT = 1'b1; bus.iClear = 1'b0;
    m_clr = 0; m_trig = 0;
    model_reset();
    repeat (3) @(posedge clk);
    check_all("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    frame(8'h1C, 0, 0, "good1C");
    chk("hist0 1C", 64'(bus.oHist[11:0]), 64'h01C);
    frame(8'hF0, 0, 0, "");
    frame(8'h1C, 0, 0, "brk1C");
    frame(8'hE0, 0, 0, "");
    frame(8'hF0, 0, 0, "");
    frame(8'h75, 0, 0, "extbrk75");
    chk("hist pair", 64'(bus.oHist[23:0]), 64'h11C375);
    chk("state 110", 64'(bus.oState), 64'b110);
    frame(8'h1C, 1, 0, "badpar");
    chk("err flag", 64'(bus.oState[0]), 64'd1);
    frame(8'h32, 0, 0, "good32");
    frame(8'h55, 3, 5, "timeout");
    frame(8'h2B, 0, 0, "good2B");
    frame(8'hE0, 0, 0, "");
    frame(8'h44, 2, 0, "badstop");
    frame(8'h44, 0, 0, "noprefix");
    for (int i = 0; i < 3; i++) begin
      bus.PS2_CLK = 1'b0;
      repeat (5) @(posedge clk);
      bus.PS2_CLK = 1'b1;
      repeat (20) @(posedge clk);
    end
    check_all("glitch");
    for (int i = 1; i <= DEP + 1; i++) frame(8'(i), 0, 0, "");
    check_all("depth");
    chk("hist 2..5", 64'(bus.oHist), 64'h002003004005);
    @(negedge clk) bus.iClear = 1'b1;
    @(negedge clk) bus.iClear = 1'b0;
    m_clr = 1; model(8'hE0, 1); m_clr = 0; m_pe = 0;
    chk("clear hist", 64'(bus.oHist), 64'd0);
    check_all("clear");
    bus.iClear = 1'b1; m_clr = 1;
    frame(8'h1C, 0, 0, "clr+evt");
    frame(8'h1C, 1, 0, "clr+bad");
    bus.iClear = 1'b0; m_clr = 0;
    for (int n = 0; n < 24; n++) begin
      int k, sel;
      logic [7:0] b;
      sel = $urandom_range(0, 3);
      b = sel == 0 ? 8'hE0 : sel == 1 ? 8'hF0 : 8'($urandom);
      k = $urandom_range(0, 9);
      frame(b, k > 3 ? 0 : k, $urandom_range(1, 10), "rand");
    end
    for (int n = 0; n < 300; n++) frame(8'h00, 3, 1, "");
    check_all("saturate");
    chk("errcnt 255", 64'(bus.oErrCnt), 64'd255);
    frame(8'h4D, 0, 0, "after sat");
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst data", 64'(bus.oData), 64'd0);
    chk("rst state", 64'(bus.oState), 64'd0);
    chk("rst hist", 64'(bus.oHist), 64'd0);
    chk("rst errcnt", 64'(bus.oErrCnt), 64'd0);
    chk("rst trig", 64'(bus.oTrig), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    frame(8'h1C, 0, 0, "post-rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
